// File: rtl/approx_dot_acc.sv
// Sequential dot-product wrapper around an external combinational 8x8 multiplier.
// Operand pairs are registered onto the multiplier and each product is accumulated the following cycle.
module approx_dot_acc #(
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);

    if (VEC_LEN < 1) begin : g_bad_len
        $error("approx_dot_acc: VEC_LEN must be >= 1");
    end
    if (ACC_W < 16 + $clog2(VEC_LEN)) begin : g_bad_width
        $error("approx_dot_acc: ACC_W too narrow for VEC_LEN products");
    end

    typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

    state_t           state;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic             pv;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             accept;

    assign in_ready  = rst_n & (state == ACC);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign mul_a     = op_a;
    assign mul_b     = op_b;

    // The product of the pair accepted last edge is added while the next pair is
    // captured, so a full-rate stream never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state <= ACC;
            cnt   <= '0;
            acc   <= '0;
            pv    <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            if (pv) begin
                acc <= acc + ACC_W'(mul_p);
            end
            unique case (state)
                ACC: begin
                    if (accept) begin
                        op_a <= in_a;
                        op_b <= in_b;
                        pv   <= 1'b1;
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(VEC_LEN - 1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        pv <= 1'b0;
                    end
                end
                DRAIN: begin
                    pv    <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: doc/approx_dot_acc.md
Name: approx_dot_acc

Overview:
- Sequential dot-product front/back end for the 8x8 approximate multiplier.
- Accepts operand pairs on a valid/ready stream, registers them onto the multiplier inputs, and captures the 16-bit product one cycle later.
- Accumulates VEC_LEN products and presents the sum on a valid/ready output.
- The multiplier itself is external: combinational, driven by mul_a/mul_b, returning mul_p in the same cycle.

Parameters:
- VEC_LEN, 8: products per dot product; must be >= 1.
- ACC_W, 24: accumulator/result width; must be >= 16 + clog2(VEC_LEN). Elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous soft clear; discards the current vector.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- mul_a  out  8  registered operand to the external multiplier.
- mul_b  out  8  registered operand to the external multiplier.
- mul_p  in  16  external multiplier product of mul_a and mul_b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  accumulated dot product.

Behaviour:
- State: ACC, DRAIN, DONE.
- Registers:
  - op_a/op_b (8b each), driving mul_a/mul_b.
  - pv: product-valid flag.
  - cnt: width clog2(VEC_LEN+1).
  - acc: ACC_W.
- Reset (rst_n=0 at a clock edge):
  - state=ACC, cnt=0, acc=0, pv=0, op_a=op_b=0.
  - out_valid=0, out_sum=0, mul_a=mul_b=0.
  - in_ready=0 while rst_n=0.
  - Reset overrides clr and all handshakes, including mid-vector and in DONE.
- clr=1 (rst_n=1): same register effect as reset on that edge. The in-flight handshake is ignored; the accepted pair is dropped.
- in_ready = rst_n & (state==ACC). Accept = in_valid & in_ready.
- ACC on accept:
  - op_a<=in_a, op_b<=in_b, pv<=1, cnt<=cnt+1.
  - If cnt==VEC_LEN-1, state<=DRAIN.
- ACC without accept: pv<=0; op regs hold.
- Every edge with pv=1: acc <= acc + zero-extend(mul_p). This runs concurrently with a new accept, so back-to-back accepts sustain 1 pair/cycle.
- DRAIN (entered with pv=1):
  - Final add.
  - pv<=0, state<=DONE.
  - in_ready=0.
- DONE:
  - out_valid=1, out_sum=acc, held stable until handshake.
  - in_ready=0; mul_p ignored.
  - On out_valid & out_ready: acc<=0, cnt<=0, state<=ACC. in_ready rises the following cycle.
- Latency: last accept at edge E → final add at E+1 → out_valid=1 from just after E+1. Earliest out handshake at edge E+2.
- out_valid, out_sum and in_ready are pure state/register decodes; no combinational path from in_valid or out_ready to any output.
- Arithmetic:
  - Unsigned.
  - The ACC_W rule guarantees no overflow; the add is modulo 2^ACC_W regardless.
- Gaps in in_valid: cnt and acc hold; pv clears after one cycle, so no product is double-counted.
- VEC_LEN=1: the first accept goes directly to DRAIN.

Test Plan:
Bench stub returns exact mul_p = mul_a*mul_b, combinational.
- VEC_LEN=4, back-to-back pairs (1,2),(3,4),(5,6),(7,8), out_ready=1 → out_valid 2 edges after last accept; out_sum=100; in_ready high again the cycle after the out handshake.
- VEC_LEN=4, four pairs (255,255) → out_sum=260100 (0x3F804), no wrap. Second vector of (0,0) → out_sum=0, confirming acc clears.
- Pairs (2,3),(4,5),(6,7),(8,9) with in_valid low 3 cycles between each → out_sum=140; no double-count from stale mul_p.
- out_ready held low 5 cycles in DONE → out_valid stays 1, out_sum constant, in_ready=0, in_valid pulses ignored. out_ready=1 → single handshake, next vector starts clean.
- clr asserted after 2 of 4 accepts, then pairs (1,1)x4 → out_sum=4.
- rst_n low one edge while in DONE → out_valid=0, out_sum=0, in_ready=1 the cycle after rst_n returns high.
- VEC_LEN=1, pair (15,17) → out_sum=255 two edges after accept.
